// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the async FIFO: default sizes and Gray-code helpers.
package fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned ASIZE_DEF = 4;
    localparam int unsigned FUNC_W    = 32;

    // Width-independent: any pointer up to FUNC_W bits, zero-extended by the caller.
    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = int'(FUNC_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: pointer/empty/level tracking and a registered
// first-word-fall-through output stage with valid/ready handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam int unsigned PTRW = ASIZE + 1;

    logic [PTRW-1:0] rq2;
    logic [PTRW-1:0] rbin;
    logic [PTRW-1:0] rbinnext;
    logic [PTRW-1:0] rgraynext;
    logic [PTRW-1:0] wbin_sync;
    logic            pop;

    fifo_sync_2ff #(.W(PTRW)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (rq2)
    );

    // Pop whenever memory has data and the output register is free or being drained.
    always_comb begin
        pop       = !rempty && (!dout_valid || dout_ready);
        rbinnext  = rbin + PTRW'(pop);
        rgraynext = PTRW'(bin2gray(FUNC_W'(rbinnext)));
        wbin_sync = PTRW'(gray2bin(FUNC_W'(rq2)));
    end

    assign raddr = rbin[ASIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            rlevel     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2);
            rlevel <= wbin_sync - rbinnext;
            if (pop) begin
                dout       <= mem_rdata;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a behavioural memory and write pointer.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [4:0] wptr;
    logic [7:0] mem_rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rlevel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    int         errors = 0;
    int         checks = 0;

    always #5 rclk = ~rclk;

    assign mem_rdata = mem[raddr];

    fifo_rd_ctrl #(.DSIZE(8), .ASIZE(4)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .wptr       (wptr),
        .mem_rdata  (mem_rdata),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .rlevel     (rlevel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] wdata(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (dout_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(dout_valid), 32'd1);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous reset values, releases mid-cycle.
    task automatic do_reset(input string p);
        rrst_n = 1'b0;
        #1;
        check({p, "_rst_rempty"}, 32'(rempty), 32'd1);
        check({p, "_rst_valid"},  32'(dout_valid), 32'd0);
        check({p, "_rst_rptr"},   32'(rptr), 32'd0);
        check({p, "_rst_raddr"},  32'(raddr), 32'd0);
        check({p, "_rst_rlevel"}, 32'(rlevel), 32'd0);
        check({p, "_rst_dout"},   32'(dout), 32'd0);
        wbin = '0;
        wptr = '0;
        dout_ready = 1'b0;
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    task automatic first_word(input logic [7:0] d, input string p);
        mem[0] = d;
        wbin = 5'd1;
        wptr = 5'b00001;
        dout_ready = 1'b0;
        tick();
        check({p, "_e1_rempty"}, 32'(rempty), 32'd1);
        tick();
        check({p, "_e2_rempty"}, 32'(rempty), 32'd1);
        tick();
        check({p, "_e3_rempty"}, 32'(rempty), 32'd0);
        check({p, "_e3_rlevel"}, 32'(rlevel), 32'd1);
        check({p, "_e3_valid"},  32'(dout_valid), 32'd0);
        tick();
        check({p, "_e4_valid"},  32'(dout_valid), 32'd1);
        check({p, "_e4_dout"},   32'(dout), 32'(d));
        check({p, "_e4_raddr"},  32'(raddr), 32'd1);
        check({p, "_e4_rptr"},   32'(rptr), 32'b00001);
        check({p, "_e4_rempty"}, 32'(rempty), 32'd1);
        check({p, "_e4_rlevel"}, 32'(rlevel), 32'd0);
    endtask

    initial begin
        int         i;
        int         wraps;
        logic [3:0] prev_raddr;

        rrst_n = 1'b1;
        wptr = 5'($urandom);
        wbin = '0;
        dout_ready = 1'($urandom);
        for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
        #2;

        do_reset("init");
        first_word(8'hA5, "fw");

        // Backpressure: three words held behind a stalled consumer.
        do_reset("bp");
        mem[0] = 8'hC0;
        mem[1] = 8'hC1;
        mem[2] = 8'hC2;
        wbin = 5'd3;
        wptr = 5'b00010;
        repeat (6) tick();
        check("bp_valid",  32'(dout_valid), 32'd1);
        check("bp_dout",   32'(dout), 32'hC0);
        check("bp_rptr",   32'(rptr), 32'b00001);
        check("bp_raddr",  32'(raddr), 32'd1);
        check("bp_rlevel", 32'(rlevel), 32'd2);
        repeat (3) tick();
        check("bp_hold_dout", 32'(dout), 32'hC0);
        check("bp_hold_rptr", 32'(rptr), 32'b00001);
        dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_drain_valid", 32'(dout_valid), 32'd1);
            check("bp_drain_dout",  32'(dout), 32'(8'hC0 + 8'(k)));
            tick();
        end
        check("bp_end_valid",  32'(dout_valid), 32'd0);
        check("bp_end_rempty", 32'(rempty), 32'd1);
        check("bp_end_rlevel", 32'(rlevel), 32'd0);

        // Full stream: 16 words, consumer always ready.
        do_reset("full");
        for (int k = 0; k < 16; k++) mem[k] = 8'h40 + 8'(k);
        wbin = 5'd16;
        wptr = 5'b11000;
        dout_ready = 1'b1;
        wait_valid("full_first", 10);
        for (int k = 0; k < 16; k++) begin
            check("full_valid",  32'(dout_valid), 32'd1);
            check("full_dout",   32'(dout), 32'(8'h40 + 8'(k)));
            check("full_rlevel", 32'(rlevel), 32'(15 - k));
            tick();
        end
        check("full_end_valid",  32'(dout_valid), 32'd0);
        check("full_end_rempty", 32'(rempty), 32'd1);
        check("full_end_rlevel", 32'(rlevel), 32'd0);

        // Wrap: 40 words in chunks of 8, pointer and address wrap.
        do_reset("wrap");
        dout_ready = 1'b1;
        wraps = 0;
        prev_raddr = 4'd0;
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < 8; j++) mem[(8*c + j) % 16] = wdata(8*c + j);
            wbin = wbin + 5'd8;
            wptr = g(wbin);
            wait_valid("wrap_wait", 8);
            for (int j = 0; j < 8; j++) begin
                i = 8*c + j;
                check("wrap_valid", 32'(dout_valid), 32'd1);
                check("wrap_dout",  32'(dout), 32'(wdata(i)));
                check("wrap_rptr",  32'(rptr), 32'(g(5'(i + 1))));
                check("wrap_raddr", 32'(raddr), 32'((i + 1) % 16));
                if (i == 30) check("wrap_rptr_31", 32'(rptr), 32'b10000);
                if (i == 31) check("wrap_rptr_0",  32'(rptr), 32'b00000);
                if (prev_raddr == 4'd15 && raddr == 4'd0) wraps++;
                prev_raddr = raddr;
                tick();
            end
        end
        check("wrap_count",  32'(wraps), 32'd2);
        check("wrap_rempty", 32'(rempty), 32'd1);

        // Reset mid-burst with a word held and five more in memory.
        do_reset("mb_pre");
        for (int k = 0; k < 6; k++) mem[k] = 8'h60 + 8'(k);
        wbin = 5'd6;
        wptr = g(5'd6);
        dout_ready = 1'b0;
        repeat (6) tick();
        check("mb_valid",  32'(dout_valid), 32'd1);
        check("mb_rlevel", 32'(rlevel), 32'd5);
        check("mb_dout",   32'(dout), 32'h60);
        do_reset("mb");
        first_word(8'h5A, "mbfw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
